kmp_pattern_loader: RTL and testbench
=====================================

Name: kmp_pattern_loader

Overview:
- Writer-side companion to the KMP matcher.
- Accepts the search pattern one character at a time over a valid/ready handshake and writes it into the pattern memory that the matcher reads.
- Then computes the KMP failure (longest-proper-prefix-suffix) table and writes it into a separate table memory.
- The matcher must not be started until `done` is high.

Parameters:
- PAT_LEN, 4, number of pattern characters; legal range 2..(2**ADDR_W - 1).
- DATA_W, 8, character width in bits.
- ADDR_W, 3, address width of both the pattern memory and the failure-table memory.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a new load; ignored unless in IDLE or DONE.
- char_valid  in  1  char_data holds a valid pattern character.
- char_data  in  DATA_W  pattern character, first character first.
- char_ready  out  1  loader accepts char_data this cycle.
- pat_we  out  1  pattern memory write enable.
- pat_addr  out  ADDR_W  pattern memory write address.
- pat_wdata  out  DATA_W  pattern memory write data.
- lps_we  out  1  failure-table write enable.
- lps_addr  out  ADDR_W  failure-table write address.
- lps_wdata  out  ADDR_W  failure value.
- busy  out  1  high in LOAD, LPS_INIT and LPS_STEP.
- done  out  1  level; tables are valid.

Behaviour:
- Reset: state IDLE; all outputs 0; internal index i=0, len=0, pattern copy registers and lps registers cleared. Reset mid-operation aborts immediately, with no further writes the cycle after rst is sampled.
- A character is accepted on any cycle where char_valid && char_ready.

States:
- IDLE:
  - start → LOAD, with i cleared to 0.
- LOAD:
  - char_ready=1.
  - Each accepted character: pat_we=1, pat_addr=i, pat_wdata=char_data (combinational from the handshake, same cycle); char_data is also copied into internal register p[i]; i increments.
  - Gaps (char_valid=0) hold state with no write.
  - On acceptance with i==PAT_LEN-1 → LPS_INIT.
  - start is ignored while busy.
- LPS_INIT (1 cycle):
  - lps_we=1, lps_addr=0, lps_wdata=0.
  - Set i=1, len=0 → LPS_STEP.
- LPS_STEP: one comparison per cycle.
  - If p[i]==p[len]: len←len+1; write lps[i]=len+1; i←i+1.
  - Else if len!=0: len←lps[len-1]. No write and i is unchanged; the value is read from the internal lps register copy.
  - Else: write lps[i]=0; i←i+1.
  - A write with i==PAT_LEN-1 → DONE.
- DONE:
  - done=1, held.
  - start → LOAD; done drops in the same cycle that LOAD is entered.

Latency and widths:
- Total latency = PAT_LEN accepted beats + 1 + (PAT_LEN-1 + number of fallback cycles).
- Fallbacks never exceed PAT_LEN-1, so LPS_STEP lasts at most 2*(PAT_LEN-1) cycles.
- len and lps values never exceed PAT_LEN-1 and fit in ADDR_W; no wrap-around.
- Each output address is written exactly once per load. pat_we and lps_we are never high in the same cycle.

Decomposition:
- Shared package kmp_pkg holds:
  - typedef for state: IDLE, LOAD, LPS_INIT, LPS_STEP, DONE;
  - constants PAT_LEN_DEF=4, CHAR_W=8, PAT_ADDR_W=3. The matcher's end-of-pattern compare must use PAT_LEN_DEF.
- Natural sub-module: kmp_lps_engine.
  - Holds i, len, and the p/lps register files, plus the LPS_STEP datapath.
  - The top-level FSM owns the handshake and the pattern memory writes.

Test Plan:
1. Load "ABAB" (41,42,41,42), char_valid held high → 4 pat writes at addr 0..3; lps writes 0,0,1,2 at addr 0..3; done rises 8 cycles after the first accept.
2. Load "AABA" (41,41,42,41) → lps 0,1,0,1. Exactly one fallback cycle with no write; done is one cycle later than in test 1.
3. Load "AAAA" → lps 0,1,2,3. Load "ABCD" → lps 0,0,0,0.
4. Backpressure: char_valid toggled 1,0,0,1,0,1,1 for "ABAB" → writes occur only on valid cycles, with addresses still 0..3 and no duplicates; results match test 1.
5. Assert rst after 2 accepted chars → next cycle all outputs 0, state IDLE. A fresh start and load of "AAAA" then gives lps 0,1,2,3.
6. Pulse start during LPS_STEP → ignored, run completes normally. start in DONE → done falls the same cycle and a new load proceeds.

Source files
------------

// File: rtl/kmp_pkg.sv
// Shared definitions for the KMP pattern loader and matcher.
// The matcher's end-of-pattern compare keys off PAT_LEN_DEF.
package kmp_pkg;
  localparam int PAT_LEN_DEF = 4;
  localparam int CHAR_W      = 8;
  localparam int PAT_ADDR_W  = 3;

  typedef logic [2:0] state_t;
  localparam state_t IDLE     = 3'd0;
  localparam state_t LOAD     = 3'd1;
  localparam state_t LPS_INIT = 3'd2;
  localparam state_t LPS_STEP = 3'd3;
  localparam state_t DONE     = 3'd4;
endpackage

// File: rtl/kmp_lps_engine.sv
// Pattern/failure-table register files plus the one-compare-per-cycle
// longest-proper-prefix-suffix datapath.
module kmp_lps_engine
  import kmp_pkg::*;
#(
  parameter int PAT_LEN = PAT_LEN_DEF,
  parameter int DATA_W  = CHAR_W,
  parameter int ADDR_W  = PAT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_data,
  input  logic              init,
  input  logic              step,
  output logic [ADDR_W-1:0] idx,
  output logic              lps_we,
  output logic [ADDR_W-1:0] lps_addr,
  output logic [ADDR_W-1:0] lps_wdata,
  output logic              last_wr
);
  // Full address-space depth keeps every index exactly ADDR_W bits wide.
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PAT_LEN - 1);

  logic [ADDR_W-1:0] i, len, len_p1, len_m1;
  logic [DEPTH-1:0][DATA_W-1:0] p;
  logic [DEPTH-1:0][ADDR_W-1:0] lps;
  logic match, len_zero, step_wr;

  assign len_p1   = len + ADDR_W'(1);
  assign len_m1   = len - ADDR_W'(1);
  assign match    = p[i] == p[len];
  assign len_zero = len == '0;
  assign step_wr  = step && (match || len_zero);

  assign idx       = i;
  assign lps_we    = init || step_wr;
  assign lps_addr  = step_wr ? i : '0;
  assign lps_wdata = (step_wr && match) ? len_p1 : '0;
  assign last_wr   = step_wr && (i == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      i   <= '0;
      len <= '0;
      p   <= '0;
      lps <= '0;
    end else if (clear) begin
      i <= '0;
    end else if (load_en) begin
      p[i] <= load_data;
      i    <= i + ADDR_W'(1);
    end else if (init) begin
      lps[0] <= '0;
      i      <= ADDR_W'(1);
      len    <= '0;
    end else if (step) begin
      if (match) begin
        len    <= len_p1;
        lps[i] <= len_p1;
        i      <= i + ADDR_W'(1);
      end else if (!len_zero) begin
        // Fallback: retry the same i against a shorter prefix.
        len <= lps[len_m1];
      end else begin
        lps[i] <= '0;
        i      <= i + ADDR_W'(1);
      end
    end
  end
endmodule

// File: rtl/kmp_pattern_loader.sv
// Loads a KMP search pattern over valid/ready into pattern memory, then
// builds the failure table; done stays high until the next start.
module kmp_pattern_loader
  import kmp_pkg::*;
#(
  parameter int PAT_LEN = PAT_LEN_DEF,
  parameter int DATA_W  = CHAR_W,
  parameter int ADDR_W  = PAT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              char_valid,
  input  logic [DATA_W-1:0] char_data,
  output logic              char_ready,
  output logic              pat_we,
  output logic [ADDR_W-1:0] pat_addr,
  output logic [DATA_W-1:0] pat_wdata,
  output logic              lps_we,
  output logic [ADDR_W-1:0] lps_addr,
  output logic [ADDR_W-1:0] lps_wdata,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PAT_LEN - 1);

  state_t state, state_nx;
  logic [ADDR_W-1:0] idx;
  logic accept, start_ok, step_last;

  assign start_ok   = start && (state == IDLE || state == DONE);
  assign char_ready = state == LOAD;
  assign accept     = char_valid && char_ready;
  assign pat_we     = accept;
  assign pat_addr   = accept ? idx : '0;
  assign pat_wdata  = accept ? char_data : '0;
  assign busy       = state == LOAD || state == LPS_INIT || state == LPS_STEP;
  assign done       = state == DONE;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start_ok) state_nx = LOAD;
      LOAD:     if (accept && idx == LAST) state_nx = LPS_INIT;
      LPS_INIT: state_nx = LPS_STEP;
      LPS_STEP: if (step_last) state_nx = DONE;
      DONE:     if (start_ok) state_nx = LOAD;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  kmp_lps_engine #(.PAT_LEN(PAT_LEN), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lps (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .load_en   (accept),
    .load_data (char_data),
    .init      (state == LPS_INIT),
    .step      (state == LPS_STEP),
    .idx       (idx),
    .lps_we    (lps_we),
    .lps_addr  (lps_addr),
    .lps_wdata (lps_wdata),
    .last_wr   (step_last)
  );
endmodule

// File: tb/tb_kmp_pattern_loader.sv
// Directed bench for kmp_pattern_loader: pattern/table contents, write
// counts, latency, backpressure, reset abort and start handling.
module tb_kmp_pattern_loader;
  logic       clk = 1'b0;
  logic       rst, start, char_valid;
  logic [7:0] char_data;
  logic       char_ready, pat_we, lps_we, busy, done;
  logic [2:0] pat_addr, lps_addr, lps_wdata;
  logic [7:0] pat_wdata;

  kmp_pattern_loader #(.PAT_LEN(4), .DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .char_valid(char_valid),
    .char_data(char_data), .char_ready(char_ready), .pat_we(pat_we),
    .pat_addr(pat_addr), .pat_wdata(pat_wdata), .lps_we(lps_we),
    .lps_addr(lps_addr), .lps_wdata(lps_wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] pat_seen [8];
  logic [2:0] lps_seen [8];
  logic [7:0] pat_mask, lps_mask;
  int pat_cnt, lps_cnt, dup, overlap, t_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rec();
    for (int k = 0; k < 8; k++) begin
      pat_seen[k] = '0;
      lps_seen[k] = '0;
    end
    pat_mask = '0; lps_mask = '0;
    pat_cnt = 0; lps_cnt = 0; dup = 0; overlap = 0; t_acc = -1;
  endtask

  task automatic record();
    if (pat_we) begin
      if (pat_mask[pat_addr]) dup++;
      pat_mask[pat_addr] = 1'b1;
      pat_seen[pat_addr] = pat_wdata;
      pat_cnt++;
      if (t_acc < 0) t_acc = cyc;
    end
    if (lps_we) begin
      if (lps_mask[lps_addr]) dup++;
      lps_mask[lps_addr] = 1'b1;
      lps_seen[lps_addr] = lps_wdata;
      lps_cnt++;
    end
    if (pat_we && lps_we) overlap++;
  endtask

  // Sample at negedge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    record();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_load(input string tag, input logic [31:0] chars,
                          input logic [15:0] vseq, input int vlen,
                          input bit pulse_step, input logic [11:0] exp_lps,
                          input int exp_lat);
    int k, t_done;
    k = 0; t_done = -1;
    clear_rec();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_enter_load"}, {29'd0, done, busy, char_ready}, 32'h3);
    for (int j = 0; j < vlen; j++) begin
      char_valid = vseq[j];
      char_data  = vseq[j] ? chars[k*8 +: 8] : 8'h00;
      tick();
      if (vseq[j]) k++;
    end
    char_valid = 1'b0;
    char_data  = 8'h00;
    if (pulse_step) begin
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_step_ignores_start"}, {30'd0, busy, done}, 32'h2);
    end
    for (int n = 0; n < 40; n++) begin
      if (done) begin
        t_done = cyc;
        break;
      end
      tick();
    end
    chk({tag, "_latency"}, t_done - t_acc, exp_lat);
    chk({tag, "_pat_data"}, {pat_seen[3], pat_seen[2], pat_seen[1], pat_seen[0]}, chars);
    chk({tag, "_pat_cnt"}, pat_cnt, 4);
    chk({tag, "_lps_data"}, {20'd0, lps_seen[3], lps_seen[2], lps_seen[1], lps_seen[0]},
        {20'd0, exp_lps});
    chk({tag, "_lps_cnt"}, lps_cnt, 4);
    chk({tag, "_dup_overlap"}, dup + overlap, 0);
  endtask

  initial begin
    int n_before;
    rst = 1'b1; start = 1'b0; char_valid = 1'b0; char_data = 8'h00;
    clear_rec();
    tick();
    tick();
    chk("reset_outputs", {char_ready, pat_we, pat_addr, pat_wdata, lps_we,
                          lps_addr, lps_wdata, busy, done}, 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_not_done", {30'd0, busy, done}, 32'h0);

    // ABAB, valid held high
    run_load("abab", 32'h42414241, 16'h000F, 4, 1'b0, {3'd2, 3'd1, 3'd0, 3'd0}, 8);
    // AABA: one fallback cycle
    run_load("aaba", 32'h41424141, 16'h000F, 4, 1'b0, {3'd1, 3'd0, 3'd1, 3'd0}, 9);
    run_load("aaaa", 32'h41414141, 16'h000F, 4, 1'b0, {3'd3, 3'd2, 3'd1, 3'd0}, 8);
    run_load("abcd", 32'h44434241, 16'h000F, 4, 1'b0, 12'h000, 8);
    // Backpressure: valid 1,0,0,1,0,1,1
    run_load("bp_abab", 32'h42414241, 16'h0069, 7, 1'b0, {3'd2, 3'd1, 3'd0, 3'd0}, 11);

    // Reset after two accepted characters
    clear_rec();
    start = 1'b1;
    tick();
    start = 1'b0;
    char_valid = 1'b1;
    char_data = 8'h41;
    tick();
    tick();
    chk("pre_reset_pat_cnt", pat_cnt, 2);
    rst = 1'b1;
    tick();
    chk("abort_outputs", {char_ready, pat_we, pat_addr, pat_wdata, lps_we,
                          lps_addr, lps_wdata, busy, done}, 32'h0);
    n_before = pat_cnt;
    tick();
    chk("abort_no_writes", pat_cnt - n_before + lps_cnt, 0);
    rst = 1'b0;
    char_valid = 1'b0;
    char_data = 8'h00;
    tick();
    run_load("post_rst_aaaa", 32'h41414141, 16'h000F, 4, 1'b0, {3'd3, 3'd2, 3'd1, 3'd0}, 8);

    // start pulsed in LPS_STEP, then restart from DONE
    run_load("pulse_abab", 32'h42414241, 16'h000F, 4, 1'b1, {3'd2, 3'd1, 3'd0, 3'd0}, 8);
    run_load("restart_abcd", 32'h44434241, 16'h000F, 4, 1'b0, 12'h000, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
